// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative radix-2 multiply/divide unit for the EX stage.
// MUL/MULH use shift-add on operand magnitudes, DIV/REM use restoring
// shift-subtract; signs are re-applied in a final FIX cycle.
// Optional build macro MULDIV_EARLY_OUT_EN: skip the 32 iterations when
// either operand is zero.
module ex_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src0,
   input  logic [WIDTH-1:0] src1,
   input  logic             flush,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [5:0]       cnt;
   logic [1:0]       op_q;
   logic             sign_a, sign_b, b_zero;
   logic [WIDTH-1:0] opnd;   // multiplicand (MUL/MULH) or divisor (DIV/REM)
   logic [WIDTH-1:0] hi;     // product high half / partial remainder
   logic [WIDTH-1:0] lo;     // multiplier / dividend, becomes product low / quotient

   logic             accept, early;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   mul_sum, div_shl, div_diff;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0] quot_s, rem_s, fix_val;

   assign accept = (state == IDLE) && start && !flush;
   assign a_mag  = src0[WIDTH-1] ? -src0 : src0;
   assign b_mag  = src1[WIDTH-1] ? -src1 : src1;

`ifdef MULDIV_EARLY_OUT_EN
   assign early = (src0 == '0) || (src1 == '0);
`else
   assign early = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = early ? FIX : CALC;
         CALC: if (flush) state_nxt = IDLE;
               else if (cnt == LAST_STEP) state_nxt = FIX;
         FIX:  state_nxt = flush ? IDLE : DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state; stall is raised combinationally in the accept cycle.
   always_comb begin
      stall = 1'b0;
      done  = 1'b0;
      case (state)
         IDLE: stall = start && !flush;
         CALC: stall = 1'b1;
         FIX:  stall = 1'b1;
         DONE: done  = 1'b1;
         default: ;
      endcase
   end

   // One radix-2 step for each operation family, plus sign correction.
   always_comb begin
      mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      div_shl  = {hi, lo[WIDTH-1]};
      div_diff = div_shl - {1'b0, opnd};
      prod_s   = (sign_a ^ sign_b) ? -{hi, lo} : {hi, lo};
      quot_s   = b_zero ? '1 : ((sign_a ^ sign_b) ? -lo : lo);
      rem_s    = sign_a ? -hi : hi;
      case (op_q)
         2'b00:   fix_val = prod_s[WIDTH-1:0];
         2'b01:   fix_val = prod_s[2*WIDTH-1:WIDTH];
         2'b10:   fix_val = quot_s;
         default: fix_val = rem_s;
      endcase
   end

   // Datapath: operand capture, iteration, and result load.
   // NOTE: only cnt and result need a reset value; the working registers are
   // always loaded on accept before they are read, so they carry no reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         result <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               op_q   <= op;
               sign_a <= src0[WIDTH-1];
               sign_b <= src1[WIDTH-1];
               b_zero <= (src1 == '0);
               cnt    <= '0;
               opnd   <= op[1] ? b_mag : a_mag;
               if (early) begin
                  // Zero operand: final magnitudes are known without iterating.
                  hi <= (op[1] && src1 == '0) ? a_mag : '0;
                  lo <= (op[1] && src1 == '0) ? '1 : '0;
               end else begin
                  hi <= '0;
                  lo <= op[1] ? a_mag : b_mag;
               end
            end
            CALC: begin
               cnt <= cnt + 6'd1;
               if (op_q[1]) begin
                  if (!div_diff[WIDTH]) begin
                     hi <= div_diff[WIDTH-1:0];
                     lo <= {lo[WIDTH-2:0], 1'b1};
                  end else begin
                     hi <= div_shl[WIDTH-1:0];
                     lo <= {lo[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  hi <= mul_sum[WIDTH:1];
                  lo <= {mul_sum[0], lo[WIDTH-1:1]};
               end
            end
            FIX: if (!flush) result <= fix_val;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv. The driver pushes expected
// results into a queue; an independent monitor pops one on every done pulse.
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [1:0]  op;
   logic [31:0] src0, src1;
   logic        stall, done;
   logic [31:0] result;

   always #5 clk = ~clk;

   ex_muldiv #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .src0   (src0),
      .src1   (src1),
      .flush  (flush),
      .stall  (stall),
      .done   (done),
      .result (result)
   );

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_result = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: signed 64-bit arithmetic, SV division truncates toward zero.
   function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa = 64'($signed(a));
      logic signed [63:0] sb = 64'($signed(b));
      logic signed [63:0] r;
      case (f)
         2'b00, 2'b01: r = sa * sb;
         2'b10:        r = (b == 0) ? -64'sd1 : sa / sb;
         default:      r = (b == 0) ? sa : sa % sb;
      endcase
      return (f == 2'b01) ? r[63:32] : r[31:0];
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         4:       return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               check("result", result, exp_q.pop_front());
            end
         end
      end
   end

   task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
      int lat      = (EARLY && (a == 0 || b == 0)) ? 2 : 34;
      int stall_n  = 0;
      int done_cyc = -1;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      start = 1'b1; op = f; src0 = a; src1 = b;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) begin
            done_cyc = c;
            check({tag, " stall_in_done"}, {31'b0, stall}, 32'd0);
            break;
         end
         if (stall) stall_n++;
      end
      @(posedge clk); #1;
      start = 1'b0; src0 = $urandom; src1 = $urandom;
      check({tag, " done_cycle"}, 32'(done_cyc), 32'(lat));
      check({tag, " stall_cycles"}, 32'(stall_n), 32'(lat));
      last_result = exp;
   endtask

   task automatic run_flush(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      start = 1'b1; op = f; src0 = a; src1 = b;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (c == 10) begin
            flush = 1'b1;
            start = 1'b0;
         end
      end
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush stall_after", {31'b0, stall}, 32'd0);
      check("flush result_held", result, last_result);
      repeat (40) @(negedge clk);
      check("flush result_still_held", result, last_result);
   endtask

   task automatic run_reset(input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      start = 1'b1; op = 2'b00; src0 = a; src1 = b;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (c == 20) begin
            rst   = 1'b1;
            start = 1'b0;
         end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst stall", {31'b0, stall}, 32'd0);
      check("rst done", {31'b0, done}, 32'd0);
      check("rst result", result, 32'd0);
      last_result = '0;
      repeat (40) @(negedge clk);
   endtask

   // Watchdog so the run can never hang.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  f;
      logic [31:0] a, b;
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src0 = '0; src1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset stall", {31'b0, stall}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      check("reset result", result, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_op(2'b00, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
      run_op(2'b01, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh_min_min");
      run_op(2'b00, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, "mul_min_min");
      run_op(2'b10, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_m7_2");
      run_op(2'b11, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_m7_2");
      run_op(2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
      run_op(2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, "rem_overflow");
      run_op(2'b10, 32'd5,          32'd0,         32'hFFFF_FFFF, "div_by_zero");
      run_op(2'b11, 32'd5,          32'd0,         32'd5,         "rem_by_zero");
      run_op(2'b11, 32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0, "rem_neg_by_zero");
      run_op(2'b01, 32'd0,          32'hFFFF_FFFF, 32'd0,         "mulh_zero");

      run_flush(2'b10, 32'd1000, 32'd7);
      a = $urandom; b = $urandom;
      run_op(2'b00, a, b, model(2'b00, a, b), "mul_after_flush");

      run_reset(32'h1234_5678, 32'h9ABC_DEF0);
      a = $urandom; b = $urandom;
      run_op(2'b01, a, b, model(2'b01, a, b), "mulh_after_rst");

      for (int i = 0; i < 60; i++) begin
         f = 2'($urandom_range(0, 3));
         a = rand_operand();
         b = rand_operand();
         run_op(f, a, b, model(f, a, b), "random");
      end

      repeat (5) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported and verified.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  EX-stage instruction is a mul/div op (held high while that instruction sits in EX).
REQ-005 SHALL have port op  input  2  operation select, sampled with start: 00 MUL (low 32 bits), 01 MULH (signed high 32 bits), 10 DIV (signed quotient), 11 REM (signed remainder).
REQ-006 SHALL have port src0  input  32  dividend/multiplicand from the EX source bus.
REQ-007 SHALL have port src1  input  32  divisor/multiplier from the EX source bus.
REQ-008 SHALL have port flush  input  1  kill the in-flight operation (branch/jump taken).
REQ-009 SHALL have port stall  output  1  stall request to the ID_EX and earlier pipeline registers.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result is valid in this cycle.
REQ-011 SHALL have port result  output  32  registered result.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 IDLE: start=1 and flush=0 SHALL capture operand magnitudes, operand signs, and op, clear the 6-bit iteration counter, and go to CALC.
REQ-014 CALC SHALL perform one radix-2 step per cycle (shift-add for MUL/MULH, restoring shift-subtract for DIV/REM) for exactly 32 cycles, then go to FIX.
REQ-015 FIX SHALL apply sign correction (two's-complement negate of product if signs differ; quotient negated if signs differ; remainder takes sign of dividend), load result, and go to DONE.
REQ-016 DONE SHALL assert done for exactly one cycle and return to IDLE unconditionally; start is ignored in DONE (same instruction still in EX).
REQ-017 stall SHALL equal (IDLE and start and not flush) or CALC or FIX; stall SHALL be low in DONE so the pipeline advances and captures result.
REQ-018 Latency: with the start cycle as cycle 0, stall SHALL be high in cycles 0..33 and done high in cycle 34.
REQ-019 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = src0.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0, with no trap.
REQ-021 MUL SHALL return bits [31:0] and MULH bits [63:32] of the signed 64-bit product.
REQ-022 flush in CALC or FIX SHALL return to IDLE on the next edge with no done pulse and result unchanged; flush in DONE SHALL not suppress the done pulse already in progress.
REQ-023 result SHALL hold its value between done pulses.

Reset
REQ-024 rst SHALL force IDLE, counter 0, done 0, result 0, and stall 0 on the next edge, including mid-CALC.
REQ-025 An operation interrupted by rst SHALL never produce done.

Configuration
REQ-026 Macro MULDIV_EARLY_OUT_EN defined: in IDLE, when start is accepted with src1==0 (any op) or src0==0, the block SHALL go directly to FIX. Stall SHALL then be high in cycles 0..1 and done high in cycle 2, with the results given by REQ-019 and REQ-021.
REQ-027 Macro MULDIV_EARLY_OUT_EN undefined: every operation SHALL take the full 34-cycle stall of REQ-018.

Verification
REQ-028 MUL src0=7, src1=0xFFFFFFFD -> result 0xFFFFFFEB; done in cycle 34; stall high for exactly 34 cycles.
REQ-029 MULH src0=src1=0x80000000 -> result 0x40000000; MUL with the same operands -> result 0x00000000.
REQ-030 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM 0xFFFFFFF9/2 -> 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-031 DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; done in cycle 2 with MULDIV_EARLY_OUT_EN and in cycle 34 without it.
REQ-032 flush asserted in cycle 10 of a DIV -> stall low from cycle 11, no done pulse, result unchanged; a new MUL started next is correct.
REQ-033 rst asserted in cycle 20 of a MUL -> all outputs 0 next cycle; done never pulses for that operation.
